sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO for buffering byte/word streams between producer and consumer blocks.

---
 rtl/sync_fifo_pkg.sv | 39 +++
 rtl/sync_fifo_param_mem_dp.sv | 49 ++++
 rtl/sync_fifo_param.sv | 166 ++++++++++++++++
 tb/tb_sync_fifo_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   - default WIDTH/DEPTH constants
//   - clog2 and pointer-width helper functions
//   - fifo_op_e: the access performed on a given clock edge
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int unsigned SF_DEF_WIDTH = 8;
    localparam int unsigned SF_DEF_DEPTH = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    // Encoding is {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_param_mem_dp.sv
// ---------------------------------------------------------------------------
// fifo_mem_dp
// WIDTH x DEPTH register-array storage for sync_fifo_param.
// One write port and one registered read port; contents are never cleared,
// only the read register returns to zero on reset.
// Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      synchronous active-high, clears rdata only
//   we     in   1      write enable
//   waddr  in   AW     write address
//   wdata  in   WIDTH  write data
//   re     in   1      read enable
//   raddr  in   AW     read address
//   rdata  out  WIDTH  registered read data, holds when re=0
// ---------------------------------------------------------------------------
module fifo_mem_dp
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = SF_DEF_WIDTH,
    parameter  int unsigned DEPTH = SF_DEF_DEPTH,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, registered status
// flags and true simultaneous read+write.
// Optional feature macro: SYNC_FIFO_ERR_EN adds sticky overflow/underflow.
// Parameters: WIDTH, DEPTH (power of 2, >= 4), AF_LEVEL, AE_LEVEL.
// Ports:
//   clk           in   1      clock, rising edge
//   reset         in   1      synchronous active-high reset
//   wr            in   1      write request, accepted when !full
//   data_in       in   WIDTH  write data
//   rd            in   1      read request, accepted when !empty
//   data_out      out  WIDTH  registered read data, 1-cycle latency
//   full          out  1      count == DEPTH
//   empty         out  1      count == 0
//   almost_full   out  1      count >= AF_LEVEL
//   almost_empty  out  1      count <= AE_LEVEL
//   count         out  AW+1   occupancy 0..DEPTH
//   overflow      out  1      (SYNC_FIFO_ERR_EN) sticky wr while full
//   underflow     out  1      (SYNC_FIFO_ERR_EN) sticky rd while empty
// ---------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH    = SF_DEF_WIDTH,
    parameter  int unsigned DEPTH    = SF_DEF_DEPTH,
    parameter  int unsigned AF_LEVEL = DEPTH - 2,
    parameter  int unsigned AE_LEVEL = 2,
    localparam int unsigned AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int unsigned   PW      = ptr_width(DEPTH);
    localparam logic [PW-1:0] C_ONE   = PW'(1);
    localparam logic [PW-1:0] C_AF    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] C_AE    = PW'(AE_LEVEL);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;

    logic          w_wa;
    logic          w_ra;
    fifo_op_e      w_op;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [PW-1:0] w_count_nxt;
    logic          w_full_nxt;
    logic          w_empty_nxt;

    assign w_wa = wr & ~r_full;
    assign w_ra = rd & ~r_empty;
    assign w_op = fifo_op_e'({w_wa, w_ra});

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        unique case (w_op)
            OP_IDLE: ;
            OP_WRITE: begin
                w_wptr_nxt  = r_wptr + C_ONE;
                w_count_nxt = r_count + C_ONE;
            end
            OP_READ: begin
                w_rptr_nxt  = r_rptr + C_ONE;
                w_count_nxt = r_count - C_ONE;
            end
            OP_BOTH: begin
                w_wptr_nxt  = r_wptr + C_ONE;
                w_rptr_nxt  = r_rptr + C_ONE;
            end
        endcase
    end

    // full/empty come from the next pointers: same slot with different wrap
    // bits means the writer has lapped the reader exactly once.
    assign w_full_nxt  = (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]) &&
                         (w_wptr_nxt[AW] != w_rptr_nxt[AW]);
    assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
            r_afull  <= (w_count_nxt >= C_AF);
            r_aempty <= (w_count_nxt <= C_AE);
        end
    end

    // Write and read slots never collide: accepted both-way access only
    // happens when neither full nor empty, so the low pointer bits differ.
    fifo_mem_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (w_wa & ~reset),
        .waddr (r_wptr[AW-1:0]),
        .wdata (data_in),
        .re    (w_ra & ~reset),
        .raddr (r_rptr[AW-1:0]),
        .rdata (data_out)
    );

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr & r_full) begin
                r_overflow <= 1'b1;
            end
            if (rd & r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFL   = 6;
    localparam int unsigned AEL   = 2;

    logic             clk;
    logic             reset;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       count;
`ifdef SYNC_FIFO_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue holding the stored words in arrival order.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_udf;

    int n_vec;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string step);
        int sz;
        sz = mq.size();
        chk({step, ":count"},        32'(count),        32'(sz));
        chk({step, ":full"},         32'(full),         32'(sz == DEPTH));
        chk({step, ":empty"},        32'(empty),        32'(sz == 0));
        chk({step, ":almost_full"},  32'(almost_full),  32'(sz >= AFL));
        chk({step, ":almost_empty"}, 32'(almost_empty), 32'(sz <= AEL));
        chk({step, ":data_out"},     32'(data_out),     32'(m_dout));
`ifdef SYNC_FIFO_ERR_EN
        chk({step, ":overflow"},     32'(overflow),     32'(m_ovf));
        chk({step, ":underflow"},    32'(underflow),    32'(m_udf));
`endif
    endtask

    // One clock: drive, predict from pre-edge occupancy, clock, check.
    task automatic cyc(input string step, input logic w, input logic r, input logic [WIDTH-1:0] d);
        int  sz;
        wr      = w;
        rd      = r;
        data_in = d;
        sz = mq.size();
        if (w && sz == DEPTH) m_ovf = 1'b1;
        if (r && sz == 0)     m_udf = 1'b1;
        if (r && sz > 0)      m_dout = mq.pop_front();
        if (w && sz < DEPTH)  mq.push_back(d);
        @(posedge clk);
        #1;
        check_all(step);
    endtask

    task automatic do_reset(input string step, input logic w, input logic r);
        reset   = 1'b1;
        wr      = w;
        rd      = r;
        data_in = WIDTH'($urandom);
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        check_all(step);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        data_in = '0;
        m_dout  = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;

        // 1: reset then idle
        do_reset("reset", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 1'b0, 8'h00);

        // 2: fill with 0x10..0x17, then a dropped write
        for (int i = 0; i < 8; i++) cyc("fill", 1'b1, 1'b0, WIDTH'(8'h10 + i));
        cyc("wr_full", 1'b1, 1'b0, 8'hFF);

        // 3: drain in order, then read while empty
        for (int i = 0; i < 8; i++) cyc("drain", 1'b0, 1'b1, 8'h00);
        cyc("rd_empty", 1'b0, 1'b1, 8'h00);
        chk("drain_last", 32'(data_out), 32'h17);

        // 4: hold occupancy 3 with simultaneous traffic, wrapping pointers
        for (int i = 0; i < 3; i++) cyc("pre3", 1'b1, 1'b0, WIDTH'($urandom));
        for (int i = 0; i < 20; i++) cyc("both3", 1'b1, 1'b1, WIDTH'($urandom));
        chk("both3_count", 32'(count), 32'd3);

        // 5: simultaneous access at empty and at full
        for (int i = 0; i < 3; i++) cyc("to_empty", 1'b0, 1'b1, 8'h00);
        cyc("both_empty", 1'b1, 1'b1, 8'hA5);
        chk("both_empty_cnt", 32'(count), 32'd1);
        for (int i = 0; i < 7; i++) cyc("to_full", 1'b1, 1'b0, WIDTH'(8'h30 + i));
        cyc("both_full", 1'b1, 1'b1, 8'hEE);
        chk("both_full_cnt", 32'(count), 32'd7);
        chk("both_full_dout", 32'(data_out), 32'hA5);

        // 6: reset with occupancy 5 and a pending write
        do_reset("reset_mid0", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("pre5", 1'b1, 1'b0, WIDTH'($urandom));
        do_reset("reset_mid", 1'b1, 1'b0);
        cyc("post_reset", 1'b0, 1'b0, 8'h00);

        // randomized traffic with varying bias toward write or read
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 100; i++) begin
                logic w;
                logic r;
                w = ($urandom_range(0, 3) < ((p % 2 == 0) ? 3 : 1));
                r = ($urandom_range(0, 3) < ((p % 2 == 0) ? 1 : 3));
                cyc("random", w, r, WIDTH'($urandom));
            end
        end
        do_reset("reset_end", 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
